// File: rtl/crop_norm_pkg.sv
// Shared types and constants for the crop/normalise frame controller.
package crop_norm_pkg;

    localparam int FRAME_CNT_W = 16;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_START     = 2'd1,
        ST_RUN       = 2'd2,
        ST_WAIT_DONE = 2'd3
    } state_e;

    // True when a requested crop origin still leaves room for the full crop window.
    function automatic logic coord_ok(input logic [15:0] coord, input logic [15:0] max_coord);
        return (coord <= max_coord);
    endfunction

endpackage

// File: rtl/crop_norm_ctrl_if.sv
// Datapath handshake bundle: pixel-stream observation plus ap_start/ap_ready/ap_done.
interface crop_norm_ctrl_if;

    logic s_axis_tvalid;
    logic s_axis_tready;
    logic ap_ready;
    logic ap_done;
    logic ap_start;

    modport master (
        output ap_start,
        input  s_axis_tvalid,
        input  s_axis_tready,
        input  ap_ready,
        input  ap_done
    );

    modport slave (
        input  ap_start,
        output s_axis_tvalid,
        output s_axis_tready,
        output ap_ready,
        output ap_done
    );

endinterface

// File: rtl/pix_pos_cnt.sv
// Column/row position of the next accepted pixel, wrapping at the frame edges.
module pix_pos_cnt #(
    parameter int COLS = 20,
    parameter int ROWS = 20
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     clr,
    input  logic                     inc,
    output logic [$clog2(COLS)-1:0]  col_r,
    output logic [$clog2(ROWS)-1:0]  row_r,
    output logic                     last_s
);

    localparam int CW = $clog2(COLS);
    localparam int RW = $clog2(ROWS);
    localparam logic [CW-1:0] COL_MAX = CW'(COLS - 1);
    localparam logic [RW-1:0] ROW_MAX = RW'(ROWS - 1);

    // Flags the final pixel of the frame.
    always_comb begin
        last_s = (col_r == COL_MAX) && (row_r == ROW_MAX);
    end

    // Position register: cleared at frame load, advanced per accepted beat.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col_r <= {CW{1'b0}};
            row_r <= {RW{1'b0}};
        end else if (clr) begin
            col_r <= {CW{1'b0}};
            row_r <= {RW{1'b0}};
        end else if (inc) begin
            if (col_r == COL_MAX) begin
                col_r <= {CW{1'b0}};
                row_r <= (row_r == ROW_MAX) ? {RW{1'b0}} : row_r + RW'(1);
            end else begin
                col_r <= col_r + CW'(1);
            end
        end
    end

endmodule

// File: rtl/crop_norm_ctrl.sv
// Crop/normalise frame controller: schedules datapath frames, latches the crop origin
// per frame, tracks pixel position and flags configuration and completion-timeout errors.
module crop_norm_ctrl
    import crop_norm_pkg::*;
#(
    parameter int IN_ROWS        = 20,
    parameter int IN_COLS        = 20,
    parameter int OUT_ROWS       = 10,
    parameter int OUT_COLS       = 10,
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic                        clk,
    input  logic                        s_axis_resetn,
    input  logic                        en,
    input  logic                        continuous,
    input  logic [$clog2(IN_COLS)-1:0]  cfg_x0,
    input  logic [$clog2(IN_ROWS)-1:0]  cfg_y0,
    input  logic                        cfg_wr,
    input  logic                        err_clr,
    crop_norm_ctrl_if.master            dp,
    output logic [$clog2(IN_COLS)-1:0]  crop_x0,
    output logic [$clog2(IN_ROWS)-1:0]  crop_y0,
    output logic [$clog2(IN_COLS)-1:0]  cnt_col,
    output logic [$clog2(IN_ROWS)-1:0]  cnt_row,
    output logic                        busy,
    output logic [FRAME_CNT_W-1:0]      frame_cnt,
    output logic                        cfg_err,
    output logic                        timeout_err
);

    localparam int CW = $clog2(IN_COLS);
    localparam int RW = $clog2(IN_ROWS);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [15:0]   X0_MAX   = 16'(IN_COLS - OUT_COLS);
    localparam logic [15:0]   Y0_MAX   = 16'(IN_ROWS - OUT_ROWS);
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

    state_e          state_r;
    state_e          state_nxt_s;
    logic            ap_start_r;
    logic            en_q_r;
    logic            pend_r;
    logic            rise_s;
    logic            start_ok_s;
    logic            beat_s;
    logic            last_s;
    logic            cfg_ok_s;
    logic            frame_load_s;
    logic            frame_done_s;
    logic            tmo_hit_s;
    logic [CW-1:0]   shadow_x_r;
    logic [RW-1:0]   shadow_y_r;
    logic [TW-1:0]   timer_r;

    assign dp.ap_start = ap_start_r;

    // Launch qualification; a pending edge covers en rising while a frame is in flight.
    always_comb begin
        rise_s     = en & ~en_q_r;
        start_ok_s = en & ~cfg_err & ~timeout_err & (continuous | rise_s | pend_r);
        beat_s     = (state_r == ST_RUN) & dp.s_axis_tvalid & dp.s_axis_tready;
        cfg_ok_s   = coord_ok(16'(cfg_x0), X0_MAX) & coord_ok(16'(cfg_y0), Y0_MAX);
    end

    // Next-state and frame event decode.
    always_comb begin
        state_nxt_s  = state_r;
        frame_load_s = 1'b0;
        frame_done_s = 1'b0;
        tmo_hit_s    = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (start_ok_s) begin
                    state_nxt_s  = ST_START;
                    frame_load_s = 1'b1;
                end else begin
                    state_nxt_s  = ST_IDLE;
                end
            end
            ST_START: begin
                if (ap_start_r && dp.ap_ready) begin
                    state_nxt_s = ST_RUN;
                end else begin
                    state_nxt_s = ST_START;
                end
            end
            ST_RUN: begin
                if (beat_s && last_s) begin
                    state_nxt_s = ST_WAIT_DONE;
                end else begin
                    state_nxt_s = ST_RUN;
                end
            end
            ST_WAIT_DONE: begin
                if (dp.ap_done) begin
                    frame_done_s = 1'b1;
                    if (continuous && en) begin
                        state_nxt_s  = ST_START;
                        frame_load_s = 1'b1;
                    end else begin
                        state_nxt_s  = ST_IDLE;
                    end
                end else if (timer_r == TMO_LAST) begin
                    tmo_hit_s   = 1'b1;
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_WAIT_DONE;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // State, handshake outputs and edge tracking; en_q resets high so a level held
    // through reset is not mistaken for a fresh rising edge.
    always_ff @(posedge clk or negedge s_axis_resetn) begin
        if (!s_axis_resetn) begin
            state_r    <= ST_IDLE;
            ap_start_r <= 1'b0;
            busy       <= 1'b0;
            en_q_r     <= 1'b1;
            pend_r     <= 1'b0;
        end else begin
            state_r    <= state_nxt_s;
            ap_start_r <= (state_nxt_s == ST_START);
            busy       <= (state_nxt_s != ST_IDLE);
            en_q_r     <= en;
            pend_r     <= en & ~frame_load_s & (pend_r | rise_s);
        end
    end

    // Shadow coordinates, active crop origin and frame counter; a load uses the old shadow.
    always_ff @(posedge clk or negedge s_axis_resetn) begin
        if (!s_axis_resetn) begin
            shadow_x_r <= {CW{1'b0}};
            shadow_y_r <= {RW{1'b0}};
            crop_x0    <= {CW{1'b0}};
            crop_y0    <= {RW{1'b0}};
            frame_cnt  <= {FRAME_CNT_W{1'b0}};
        end else begin
            if (cfg_wr && cfg_ok_s) begin
                shadow_x_r <= cfg_x0;
                shadow_y_r <= cfg_y0;
            end
            if (frame_load_s) begin
                crop_x0 <= shadow_x_r;
                crop_y0 <= shadow_y_r;
            end
            if (frame_done_s) begin
                frame_cnt <= frame_cnt + FRAME_CNT_W'(1);
            end
        end
    end

    // Sticky error flags (a new error wins over err_clr) and the completion timer.
    always_ff @(posedge clk or negedge s_axis_resetn) begin
        if (!s_axis_resetn) begin
            cfg_err     <= 1'b0;
            timeout_err <= 1'b0;
            timer_r     <= {TW{1'b0}};
        end else begin
            cfg_err     <= (cfg_wr & ~cfg_ok_s) | (cfg_err & ~err_clr);
            timeout_err <= tmo_hit_s | (timeout_err & ~err_clr);
            timer_r     <= (state_r == ST_WAIT_DONE) ? timer_r + TW'(1) : {TW{1'b0}};
        end
    end

    pix_pos_cnt #(
        .COLS (IN_COLS),
        .ROWS (IN_ROWS)
    ) u_pos (
        .clk    (clk),
        .rst_n  (s_axis_resetn),
        .clr    (frame_load_s),
        .inc    (beat_s),
        .col_r  (cnt_col),
        .row_r  (cnt_row),
        .last_s (last_s)
    );

endmodule

// File: tb/tb_crop_norm_ctrl.sv
// Directed-plus-random bench for crop_norm_ctrl; expected positions come from a beat count.
module tb_crop_norm_ctrl;

    localparam int IR   = 20;
    localparam int IC   = 20;
    localparam int TMO  = 16;
    localparam int NPIX = IR * IC;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        en;
    logic        continuous;
    logic [4:0]  cfg_x0;
    logic [4:0]  cfg_y0;
    logic        cfg_wr;
    logic        err_clr;
    logic [4:0]  crop_x0;
    logic [4:0]  crop_y0;
    logic [4:0]  cnt_col;
    logic [4:0]  cnt_row;
    logic        busy;
    logic [15:0] frame_cnt;
    logic        cfg_err;
    logic        timeout_err;

    int nchk = 0;
    int nerr = 0;
    int exp_frames = 0;

    crop_norm_ctrl_if dpif ();

    crop_norm_ctrl #(
        .IN_ROWS        (IR),
        .IN_COLS        (IC),
        .OUT_ROWS       (10),
        .OUT_COLS       (10),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .clk           (clk),
        .s_axis_resetn (rst_n),
        .en            (en),
        .continuous    (continuous),
        .cfg_x0        (cfg_x0),
        .cfg_y0        (cfg_y0),
        .cfg_wr        (cfg_wr),
        .err_clr       (err_clr),
        .dp            (dpif),
        .crop_x0       (crop_x0),
        .crop_y0       (crop_y0),
        .cnt_col       (cnt_col),
        .cnt_row       (cnt_row),
        .busy          (busy),
        .frame_cnt     (frame_cnt),
        .cfg_err       (cfg_err),
        .timeout_err   (timeout_err)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog observed=running expected=finished");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nchk++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic en_pulse();
        en = 1'b1;
        tick();
        en = 1'b0;
    endtask

    task automatic cfg_write(input int x, input int y);
        cfg_x0 = 5'(x);
        cfg_y0 = 5'(y);
        cfg_wr = 1'b1;
        tick();
        cfg_wr = 1'b0;
    endtask

    task automatic err_clear();
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_ap_start"}, 32'(dpif.ap_start), 32'd0);
        chk({tag, "_crop_x0"},  32'(crop_x0), 32'd0);
        chk({tag, "_crop_y0"},  32'(crop_y0), 32'd0);
        chk({tag, "_cnt_col"},  32'(cnt_col), 32'd0);
        chk({tag, "_cnt_row"},  32'(cnt_row), 32'd0);
        chk({tag, "_busy"},     32'(busy), 32'd0);
        chk({tag, "_frame_cnt"}, 32'(frame_cnt), 32'd0);
        chk({tag, "_cfg_err"},  32'(cfg_err), 32'd0);
        chk({tag, "_tmo_err"},  32'(timeout_err), 32'd0);
    endtask

    // Waits for ap_start, handshakes it and streams nbeats randomly gapped beats.
    task automatic frame_body(input string tag, input int x0, input int y0, input int nbeats);
        int  n;
        int  guard;
        logic v;
        logic r;
        for (int i = 0; i < 20 && dpif.ap_start !== 1'b1; i++) tick();
        chk({tag, "_ap_start"}, 32'(dpif.ap_start), 32'd1);
        chk({tag, "_crop_x0"},  32'(crop_x0), 32'(x0));
        chk({tag, "_crop_y0"},  32'(crop_y0), 32'(y0));
        chk({tag, "_busy"},     32'(busy), 32'd1);
        chk({tag, "_cnt0"},     32'({cnt_row, cnt_col}), 32'd0);
        dpif.ap_ready = 1'b1;
        tick();
        dpif.ap_ready = 1'b0;
        chk({tag, "_run_ap_start"}, 32'(dpif.ap_start), 32'd0);
        n = 0;
        guard = 0;
        while (n < nbeats && guard < 20000) begin
            v = ($urandom_range(0, 3) != 0);
            r = ($urandom_range(0, 3) != 0);
            dpif.s_axis_tvalid = v;
            dpif.s_axis_tready = r;
            tick();
            guard++;
            if (v && r) n++;
            chk({tag, "_col"}, 32'(cnt_col), 32'((n % NPIX) % IC));
            chk({tag, "_row"}, 32'(cnt_row), 32'((n % NPIX) / IC));
        end
        dpif.s_axis_tvalid = 1'b0;
        dpif.s_axis_tready = 1'b0;
        chk({tag, "_beats"}, 32'(n), 32'(nbeats));
        if (nbeats == NPIX) begin
            chk({tag, "_wait_busy"}, 32'(busy), 32'd1);
        end
    endtask

    // Holds off ap_done for delay cycles (offering ignored beats), then completes the frame.
    task automatic finish_frame(input string tag, input int delay, input logic busy_after);
        for (int i = 0; i < delay; i++) begin
            dpif.s_axis_tvalid = 1'b1;
            dpif.s_axis_tready = 1'b1;
            tick();
            chk({tag, "_ign_cnt"}, 32'({cnt_row, cnt_col}), 32'd0);
            chk({tag, "_ign_busy"}, 32'(busy), 32'd1);
        end
        dpif.ap_done = 1'b1;
        tick();
        dpif.ap_done = 1'b0;
        dpif.s_axis_tvalid = 1'b0;
        dpif.s_axis_tready = 1'b0;
        exp_frames++;
        chk({tag, "_frame_cnt"}, 32'(frame_cnt), 32'(exp_frames % 65536));
        chk({tag, "_busy_after"}, 32'(busy), 32'(busy_after));
        chk({tag, "_cnt_after"}, 32'({cnt_row, cnt_col}), 32'd0);
    endtask

    initial begin
        rst_n = 1'b0;
        en = 1'b0;
        continuous = 1'b0;
        cfg_x0 = 5'd0;
        cfg_y0 = 5'd0;
        cfg_wr = 1'b0;
        err_clr = 1'b0;
        dpif.s_axis_tvalid = 1'b0;
        dpif.s_axis_tready = 1'b0;
        dpif.ap_ready = 1'b0;
        dpif.ap_done = 1'b0;
        tick();
        tick();
        chk_all_zero("rst");
        rst_n = 1'b1;
        tick();
        chk("rst_rel_busy", 32'(busy), 32'd0);

        // Single frame at (5,7) with ap_done three cycles late.
        cfg_write(5, 7);
        chk("t1_cfg_err", 32'(cfg_err), 32'd0);
        en_pulse();
        frame_body("t1", 5, 7, NPIX);
        finish_frame("t1", 3, 1'b0);

        // Out-of-range origin: rejected, sticky, blocks launch until cleared.
        cfg_write(11, 0);
        chk("t2_cfg_err", 32'(cfg_err), 32'd1);
        en_pulse();
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("t2_blocked", 32'(busy), 32'd0);
        end
        err_clear();
        chk("t2_cleared", 32'(cfg_err), 32'd0);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("t2_no_stale", 32'(busy), 32'd0);
        end
        en_pulse();
        frame_body("t2", 5, 7, NPIX);
        finish_frame("t2", 2, 1'b0);
        cfg_write(10, 10);
        chk("t2_edge_ok", 32'(cfg_err), 32'd0);
        cfg_write(0, 11);
        chk("t2_y_bad", 32'(cfg_err), 32'd1);
        err_clear();
        cfg_x0 = 5'd15;
        cfg_wr = 1'b1;
        err_clr = 1'b1;
        tick();
        cfg_wr = 1'b0;
        err_clr = 1'b0;
        chk("t2_set_wins", 32'(cfg_err), 32'd1);
        err_clear();
        chk("t2_clr2", 32'(cfg_err), 32'd0);

        // Config write coinciding with launch takes effect one frame later.
        cfg_write(4, 4);
        cfg_x0 = 5'd2;
        cfg_y0 = 5'd2;
        cfg_wr = 1'b1;
        en = 1'b1;
        tick();
        cfg_wr = 1'b0;
        en = 1'b0;
        frame_body("t3a", 4, 4, NPIX);
        finish_frame("t3a", 1, 1'b0);
        en_pulse();
        frame_body("t3b", 2, 2, NPIX);

        // Withheld ap_done: timeout exactly TMO cycles after the last beat.
        for (int k = 1; k < TMO; k++) begin
            tick();
            chk("t4_no_tmo", 32'(timeout_err), 32'd0);
            chk("t4_busy", 32'(busy), 32'd1);
        end
        tick();
        chk("t4_tmo", 32'(timeout_err), 32'd1);
        chk("t4_idle", 32'(busy), 32'd0);
        chk("t4_frames", 32'(frame_cnt), 32'(exp_frames));
        en_pulse();
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("t4_held", 32'(busy), 32'd0);
        end
        err_clear();
        chk("t4_cleared", 32'(timeout_err), 32'd0);

        // Continuous mode: three back-to-back frames.
        continuous = 1'b1;
        en = 1'b1;
        for (int f = 0; f < 3; f++) begin
            frame_body("t5", 2, 2, NPIX);
            if (f == 2) begin
                continuous = 1'b0;
                en = 1'b0;
            end
            finish_frame("t5", $urandom_range(0, 5), (f < 2));
        end

        // Reset mid-frame at beat 150 with en held high across release.
        en_pulse();
        frame_body("t6", 2, 2, 150);
        en = 1'b1;
        rst_n = 1'b0;
        #1;
        chk_all_zero("t6_rst");
        tick();
        tick();
        rst_n = 1'b1;
        exp_frames = 0;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("t6_no_start", 32'(busy), 32'd0);
        end
        en = 1'b0;
        tick();
        en = 1'b1;
        tick();
        en = 1'b0;
        frame_body("t6b", 0, 0, NPIX);
        finish_frame("t6b", 2, 1'b0);

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule
